// File: rtl/cn_nonce_scheduler.sv
// Nonce work scheduler: issues a nonce range into pre_CN under a credit limit,
// tags each job with a slot ID, and restores full nonces from tagged results.
module cn_nonce_scheduler #(
  parameter int unsigned NONCE_WIDTH = 32,
  parameter int unsigned TAG_WIDTH   = 3
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   i_start,
  input  logic                   i_abort,
  input  logic [NONCE_WIDTH-1:0] i_nonce_base,
  input  logic [NONCE_WIDTH-1:0] i_nonce_count,
  input  logic [TAG_WIDTH:0]     i_max_inflight,
  output logic                   o_busy,
  output logic                   o_done,
  output logic                   o_err,
  output logic                   o_valid,
  output logic [NONCE_WIDTH-1:0] o_nonce,
  output logic [TAG_WIDTH-1:0]   o_tag,
  input  logic                   i_ready,
  input  logic                   i_res_valid,
  input  logic [TAG_WIDTH-1:0]   i_res_tag,
  output logic                   o_res_ready,
  output logic                   o_out_valid,
  output logic [NONCE_WIDTH-1:0] o_out_nonce,
  input  logic                   i_out_ready
);

  localparam int unsigned SLOTS = 1 << TAG_WIDTH;
  localparam int unsigned CW    = TAG_WIDTH + 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_e;

  state_e                 state_q, state_d;
  logic [NONCE_WIDTH-1:0] base_q, base_d;
  logic [NONCE_WIDTH-1:0] count_q, count_d;
  logic [NONCE_WIDTH-1:0] issued_q, issued_d;
  logic [CW-1:0]          limit_q, limit_d;
  logic [CW-1:0]          inflight_q, inflight_d;
  logic [SLOTS-1:0]       slot_busy_q, slot_busy_d;
  logic                   abort_q, abort_d;
  logic                   valid_q, valid_d;
  logic [NONCE_WIDTH-1:0] nonce_q, nonce_d;
  logic [TAG_WIDTH-1:0]   tag_q, tag_d;
  logic                   out_valid_q, out_valid_d;
  logic [NONCE_WIDTH-1:0] out_nonce_q, out_nonce_d;
  logic                   err_q, err_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic [NONCE_WIDTH-1:0] table_q [SLOTS];

  logic                   free_found;
  logic [TAG_WIDTH-1:0]   free_tag;
  logic                   issue_hs, res_ready_c, res_fire, res_hit, abort_any;
  logic [NONCE_WIDTH-1:0] issued_nx;
  logic [CW-1:0]          limit_c;

  // Lowest-index free slot from the registered bitmap
  always_comb begin
    free_found = 1'b0;
    free_tag   = '0;
    for (int unsigned i = 0; i < SLOTS; i++) begin
      if (!slot_busy_q[TAG_WIDTH'(i)] && !free_found) begin
        free_found = 1'b1;
        free_tag   = TAG_WIDTH'(i);
      end
    end
  end

  assign issue_hs    = valid_q & i_ready;
  assign res_ready_c = ~out_valid_q | i_out_ready;
  assign res_fire    = i_res_valid & res_ready_c;
  assign res_hit     = res_fire & slot_busy_q[i_res_tag];
  assign issued_nx   = issued_q + NONCE_WIDTH'(issue_hs);
  assign abort_any   = abort_q | i_abort;
  assign limit_c     = ((i_max_inflight == '0) || (i_max_inflight > CW'(SLOTS)))
                       ? CW'(SLOTS) : i_max_inflight;

  // Next-state, issue offer and result restore logic
  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    count_d     = count_q;
    issued_d    = issued_q;
    limit_d     = limit_q;
    inflight_d  = inflight_q + CW'(issue_hs) - CW'(res_hit);
    slot_busy_d = slot_busy_q;
    abort_d     = abort_q;
    valid_d     = valid_q;
    nonce_d     = nonce_q;
    tag_d       = tag_q;
    out_valid_d = out_valid_q;
    out_nonce_d = out_nonce_q;
    err_d       = err_q;

    if (res_hit) slot_busy_d[i_res_tag] = 1'b0;
    if (issue_hs) begin
      slot_busy_d[tag_q] = 1'b1;
      valid_d            = 1'b0;
      issued_d           = issued_nx;
    end

    if (res_hit) begin
      out_valid_d = 1'b1;
      out_nonce_d = table_q[i_res_tag];
    end else if (i_out_ready) begin
      out_valid_d = 1'b0;
    end

    unique case (state_q)
      S_IDLE: begin
        if (i_start) begin
          base_d   = i_nonce_base;
          count_d  = i_nonce_count;
          limit_d  = limit_c;
          issued_d = '0;
          abort_d  = 1'b0;
          err_d    = 1'b0;
          state_d  = (i_nonce_count == '0) ? S_DRAIN : S_ISSUE;
        end
      end
      S_ISSUE: begin
        abort_d = abort_any;
        if (!valid_q && !abort_any && (issued_q < count_q) &&
            (inflight_q < limit_q) && free_found) begin
          valid_d = 1'b1;
          nonce_d = base_q + issued_q;
          tag_d   = free_tag;
        end
        // A pending offer always completes its handshake before leaving
        if (!valid_d && (abort_any || (issued_nx == count_q))) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        abort_d = 1'b0;
        if ((inflight_q == '0) && !out_valid_q) state_d = S_DONE;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Result on a tag that is not outstanding is consumed and flagged
    if (res_fire && !slot_busy_q[i_res_tag]) err_d = 1'b1;

    busy_d = (state_d == S_ISSUE) || (state_d == S_DRAIN);
    done_d = (state_d == S_DONE);
  end

  // Control and output registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= S_IDLE;
      base_q      <= '0;
      count_q     <= '0;
      issued_q    <= '0;
      limit_q     <= '0;
      inflight_q  <= '0;
      slot_busy_q <= '0;
      abort_q     <= 1'b0;
      valid_q     <= 1'b0;
      nonce_q     <= '0;
      tag_q       <= '0;
      out_valid_q <= 1'b0;
      out_nonce_q <= '0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      count_q     <= count_d;
      issued_q    <= issued_d;
      limit_q     <= limit_d;
      inflight_q  <= inflight_d;
      slot_busy_q <= slot_busy_d;
      abort_q     <= abort_d;
      valid_q     <= valid_d;
      nonce_q     <= nonce_d;
      tag_q       <= tag_d;
      out_valid_q <= out_valid_d;
      out_nonce_q <= out_nonce_d;
      err_q       <= err_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  // Slot nonce table, written on issue handshake (contents need no reset)
  always_ff @(posedge clk) begin
    if (issue_hs) table_q[tag_q] <= nonce_q;
  end

  assign o_busy      = busy_q;
  assign o_done      = done_q;
  assign o_err       = err_q;
  assign o_valid     = valid_q;
  assign o_nonce     = nonce_q;
  assign o_tag       = tag_q;
  assign o_res_ready = res_ready_c;
  assign o_out_valid = out_valid_q;
  assign o_out_nonce = out_nonce_q;

endmodule

// File: tb/tb_cn_nonce_scheduler.sv
// Directed testbench for cn_nonce_scheduler with a CN loopback model.
module tb_cn_nonce_scheduler;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        i_start = 1'b0, i_abort = 1'b0, i_ready = 1'b1;
  logic        i_res_valid = 1'b0, i_out_ready = 1'b1;
  logic [31:0] i_nonce_base = '0, i_nonce_count = '0;
  logic [3:0]  i_max_inflight = '0;
  logic [2:0]  i_res_tag = '0;
  logic        o_busy, o_done, o_err, o_valid, o_res_ready, o_out_valid;
  logic [31:0] o_nonce, o_out_nonce;
  logic [2:0]  o_tag;

  cn_nonce_scheduler #(.NONCE_WIDTH(32), .TAG_WIDTH(3)) dut (
    .clk(clk), .rstn(rstn), .i_start(i_start), .i_abort(i_abort),
    .i_nonce_base(i_nonce_base), .i_nonce_count(i_nonce_count),
    .i_max_inflight(i_max_inflight), .o_busy(o_busy), .o_done(o_done),
    .o_err(o_err), .o_valid(o_valid), .o_nonce(o_nonce), .o_tag(o_tag),
    .i_ready(i_ready), .i_res_valid(i_res_valid), .i_res_tag(i_res_tag),
    .o_res_ready(o_res_ready), .o_out_valid(o_out_valid),
    .o_out_nonce(o_out_nonce), .i_out_ready(i_out_ready)
  );

  always #5 clk = ~clk;

  typedef struct { logic [2:0] tag; int due; } lb_t;

  int          tests = 0, fails = 0;
  int          cyc = 0;
  bit          lb_en = 1'b0, rand_or = 1'b0;
  int          lb_lat = 20;
  lb_t         lbq[$];
  logic [31:0] iss_n[$];
  logic [2:0]  iss_t[$];
  logic [31:0] rx_n[$];
  int          done_cnt = 0, out_cnt = 0, max_out = 0, rr_bad = 0;

  // Observe handshakes on the active edge using pre-edge values
  always @(posedge clk) begin
    cyc++;
    if (rstn) begin
      if (o_res_ready !== (~o_out_valid | i_out_ready)) rr_bad++;
      if (i_res_valid && o_res_ready) begin
        out_cnt--;
        if (lb_en && lbq.size() > 0) lbq.delete(0);
      end
      if (o_valid && i_ready) begin
        iss_n.push_back(o_nonce);
        iss_t.push_back(o_tag);
        out_cnt++;
        if (out_cnt > max_out) max_out = out_cnt;
        if (lb_en) lbq.push_back('{o_tag, cyc + lb_lat});
      end
      if (o_out_valid && i_out_ready) rx_n.push_back(o_out_nonce);
    end
  end

  // Drive loopback results and downstream ready on the falling edge
  always @(negedge clk) begin
    i_out_ready = rand_or ? 1'($urandom_range(0, 1)) : 1'b1;
    if (o_done === 1'b1) done_cnt++;
    if (lb_en) begin
      if (lbq.size() > 0 && cyc >= lbq[0].due) begin
        i_res_valid = 1'b1;
        i_res_tag   = lbq[0].tag;
      end else begin
        i_res_valid = 1'b0;
      end
    end
  end

  task automatic clear_logs();
    iss_n.delete(); iss_t.delete(); rx_n.delete(); lbq.delete();
    done_cnt = 0; out_cnt = 0; max_out = 0; rr_bad = 0;
  endtask

  task automatic start_job(input logic [31:0] base, input logic [31:0] cnt,
                           input logic [3:0] lim);
    @(negedge clk);
    i_nonce_base = base; i_nonce_count = cnt; i_max_inflight = lim; i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
  endtask

  task automatic wait_done(input int max_cyc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (o_done === 1'b1) begin ok = 1'b1; break; end
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    tests++; if (o_busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", o_busy); end
    tests++; if (o_done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b want 0", o_done); end
    tests++; if (o_err !== 1'b0) begin fails++; $display("FAIL reset_err: got %b want 0", o_err); end
    tests++; if (o_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", o_valid); end
    tests++; if (o_nonce !== 32'h0 || o_tag !== 3'd0) begin fails++; $display("FAIL reset_nonce_tag: got %h/%0d want 0/0", o_nonce, o_tag); end
    tests++; if (o_out_valid !== 1'b0 || o_out_nonce !== 32'h0) begin fails++; $display("FAIL reset_out: got %b/%h want 0/0", o_out_valid, o_out_nonce); end
    tests++; if (o_res_ready !== 1'b1) begin fails++; $display("FAIL reset_res_ready: got %b want 1", o_res_ready); end
    rstn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    bit ok;
    clear_logs(); lb_lat = 20; lb_en = 1'b1;
    start_job(32'h10, 32'd5, 4'd2);
    wait_done(1000, ok);
    tests++; if (!ok) begin fails++; $display("FAIL basic_done_timeout: got none want o_done"); end
    tests++; if (iss_n.size() != 5) begin fails++; $display("FAIL basic_issue_count: got %0d want 5", iss_n.size()); end
    if (iss_n.size() == 5)
      for (int i = 0; i < 5; i++) begin
        tests++; if (iss_n[i] !== 32'h10 + 32'(i)) begin fails++; $display("FAIL basic_nonce[%0d]: got %h want %h", i, iss_n[i], 32'h10 + 32'(i)); end
      end
    if (iss_t.size() >= 2) begin
      tests++; if (iss_t[0] !== 3'd0 || iss_t[1] !== 3'd1) begin fails++; $display("FAIL basic_tags: got %0d,%0d want 0,1", iss_t[0], iss_t[1]); end
    end
    tests++; if (max_out != 2) begin fails++; $display("FAIL basic_max_inflight: got %0d want 2", max_out); end
    tests++; if (rx_n.size() != 5) begin fails++; $display("FAIL basic_rx_count: got %0d want 5", rx_n.size()); end
    if (rx_n.size() == 5)
      for (int i = 0; i < 5; i++) begin
        tests++; if (rx_n[i] !== 32'h10 + 32'(i)) begin fails++; $display("FAIL basic_rx[%0d]: got %h want %h", i, rx_n[i], 32'h10 + 32'(i)); end
      end
    tests++; if (done_cnt != 1) begin fails++; $display("FAIL basic_done_pulses: got %0d want 1", done_cnt); end
    lb_en = 1'b0;
  endtask

  task automatic test_wrap();
    bit ok;
    logic [31:0] exp_n [4];
    exp_n = '{32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000000, 32'h00000001};
    clear_logs(); lb_lat = 20; lb_en = 1'b1;
    start_job(32'hFFFFFFFE, 32'd4, 4'd0);
    wait_done(1000, ok);
    tests++; if (!ok) begin fails++; $display("FAIL wrap_done_timeout: got none want o_done"); end
    tests++; if (max_out != 4) begin fails++; $display("FAIL wrap_max_inflight: got %0d want 4", max_out); end
    tests++; if (iss_n.size() != 4 || rx_n.size() != 4) begin fails++; $display("FAIL wrap_counts: got %0d/%0d want 4/4", iss_n.size(), rx_n.size()); end
    if (iss_n.size() == 4 && rx_n.size() == 4)
      for (int i = 0; i < 4; i++) begin
        tests++; if (iss_n[i] !== exp_n[i]) begin fails++; $display("FAIL wrap_nonce[%0d]: got %h want %h", i, iss_n[i], exp_n[i]); end
        tests++; if (rx_n[i] !== exp_n[i]) begin fails++; $display("FAIL wrap_rx[%0d]: got %h want %h", i, rx_n[i], exp_n[i]); end
      end
    lb_en = 1'b0;
  endtask

  task automatic test_zero_count();
    clear_logs();
    start_job(32'h1234, 32'd0, 4'd3);
    tests++; if (o_busy !== 1'b1 || o_done !== 1'b0 || o_valid !== 1'b0) begin fails++; $display("FAIL zero_c1: got busy=%b done=%b valid=%b want 1/0/0", o_busy, o_done, o_valid); end
    @(negedge clk);
    tests++; if (o_busy !== 1'b0 || o_done !== 1'b1 || o_valid !== 1'b0) begin fails++; $display("FAIL zero_c2: got busy=%b done=%b valid=%b want 0/1/0", o_busy, o_done, o_valid); end
    @(negedge clk);
    tests++; if (o_busy !== 1'b0 || o_done !== 1'b0) begin fails++; $display("FAIL zero_c3: got busy=%b done=%b want 0/0", o_busy, o_done); end
    tests++; if (iss_n.size() != 0) begin fails++; $display("FAIL zero_issues: got %0d want 0", iss_n.size()); end
  endtask

  task automatic test_abort_stall();
    bit ok, seen;
    int unstable;
    logic [31:0] n0;
    logic [2:0]  t0;
    clear_logs(); lb_lat = 5; lb_en = 1'b1;
    @(negedge clk); i_ready = 1'b0;
    start_job(32'h500, 32'd6, 4'd4);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (o_valid === 1'b1) begin seen = 1'b1; break; end
      @(negedge clk);
    end
    tests++; if (!seen) begin fails++; $display("FAIL abort_offer_timeout: got no o_valid want offer"); end
    n0 = o_nonce; t0 = o_tag;
    tests++; if (n0 !== 32'h500 || t0 !== 3'd0) begin fails++; $display("FAIL abort_first_offer: got %h/%0d want 00000500/0", n0, t0); end
    unstable = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      i_abort = (i == 4);
      if (o_valid !== 1'b1 || o_nonce !== n0 || o_tag !== t0) unstable++;
    end
    i_abort = 1'b0;
    tests++; if (unstable != 0) begin fails++; $display("FAIL abort_stall_stable: got %0d unstable cycles want 0", unstable); end
    i_ready = 1'b1;
    wait_done(200, ok);
    tests++; if (!ok) begin fails++; $display("FAIL abort_done_timeout: got none want o_done"); end
    tests++; if (iss_n.size() != 1) begin fails++; $display("FAIL abort_issue_count: got %0d want 1", iss_n.size()); end
    tests++; if (rx_n.size() != 1 || (rx_n.size() == 1 && rx_n[0] !== 32'h500)) begin fails++; $display("FAIL abort_drain: got %0d results want 1 of 00000500", rx_n.size()); end
    tests++; if (done_cnt != 1) begin fails++; $display("FAIL abort_done_pulses: got %0d want 1", done_cnt); end
    lb_en = 1'b0;
  endtask

  task automatic test_out_of_order();
    bit ok, acc;
    logic [2:0]  order [3];
    logic [31:0] exp_n [3];
    order = '{3'd2, 3'd0, 3'd1};
    exp_n = '{32'h1002, 32'h1000, 32'h1001};
    clear_logs(); lb_en = 1'b0; i_res_valid = 1'b0;
    start_job(32'h1000, 32'd3, 4'd3);
    for (int i = 0; i < 50 && iss_n.size() < 3; i++) @(negedge clk);
    tests++; if (iss_t.size() != 3) begin fails++; $display("FAIL ooo_issue_count: got %0d want 3", iss_t.size()); end
    else begin
      tests++; if (iss_t[0] !== 3'd0 || iss_t[1] !== 3'd1 || iss_t[2] !== 3'd2) begin fails++; $display("FAIL ooo_tags: got %0d,%0d,%0d want 0,1,2", iss_t[0], iss_t[1], iss_t[2]); end
    end
    rand_or = 1'b1;
    for (int r = 0; r < 3; r++) begin
      @(negedge clk);
      i_res_valid = 1'b1; i_res_tag = order[r];
      acc = 1'b0;
      for (int k = 0; k < 50; k++) begin
        @(posedge clk);
        if (o_res_ready === 1'b1) begin acc = 1'b1; break; end
      end
      tests++; if (!acc) begin fails++; $display("FAIL ooo_accept[%0d]: got no o_res_ready want accept", r); end
    end
    @(negedge clk); i_res_valid = 1'b0;
    for (int i = 0; i < 100 && rx_n.size() < 3; i++) @(negedge clk);
    rand_or = 1'b0;
    wait_done(100, ok);
    tests++; if (!ok) begin fails++; $display("FAIL ooo_done_timeout: got none want o_done"); end
    tests++; if (rx_n.size() != 3) begin fails++; $display("FAIL ooo_rx_count: got %0d want 3", rx_n.size()); end
    if (rx_n.size() == 3)
      for (int i = 0; i < 3; i++) begin
        tests++; if (rx_n[i] !== exp_n[i]) begin fails++; $display("FAIL ooo_rx[%0d]: got %h want %h", i, rx_n[i], exp_n[i]); end
      end
    tests++; if (o_err !== 1'b0) begin fails++; $display("FAIL ooo_err: got %b want 0", o_err); end
    tests++; if (rr_bad != 0) begin fails++; $display("FAIL ooo_res_ready_rule: got %0d bad cycles want 0", rr_bad); end
    tests++; if (done_cnt != 1) begin fails++; $display("FAIL ooo_done_pulses: got %0d want 1", done_cnt); end
  endtask

  task automatic test_err_and_async_reset();
    clear_logs(); lb_en = 1'b0;
    @(negedge clk); i_res_valid = 1'b1; i_res_tag = 3'd5;
    @(negedge clk); i_res_valid = 1'b0;
    tests++; if (o_err !== 1'b1) begin fails++; $display("FAIL err_spurious: got %b want 1", o_err); end
    tests++; if (o_out_valid !== 1'b0) begin fails++; $display("FAIL err_dropped: got out_valid %b want 0", o_out_valid); end
    clear_logs(); lb_lat = 30; lb_en = 1'b1;
    start_job(32'h0, 32'd100, 4'd2);
    tests++; if (o_err !== 1'b0 || o_busy !== 1'b1) begin fails++; $display("FAIL err_clear_on_start: got err=%b busy=%b want 0/1", o_err, o_busy); end
    repeat (6) @(negedge clk);
    tests++; if (o_busy !== 1'b1 || iss_n.size() == 0) begin fails++; $display("FAIL rst_mid_issue_setup: got busy=%b issues=%0d want 1/>0", o_busy, iss_n.size()); end
    #2;
    rstn = 1'b0; lb_en = 1'b0; lbq.delete(); i_res_valid = 1'b0;
    #1;
    tests++; if (o_busy !== 1'b0 || o_valid !== 1'b0 || o_done !== 1'b0 || o_err !== 1'b0) begin fails++; $display("FAIL async_rst_ctrl: got busy=%b valid=%b done=%b err=%b want 0/0/0/0", o_busy, o_valid, o_done, o_err); end
    tests++; if (o_nonce !== 32'h0 || o_tag !== 3'd0 || o_out_valid !== 1'b0 || o_out_nonce !== 32'h0) begin fails++; $display("FAIL async_rst_data: got %h/%0d/%b/%h want 0/0/0/0", o_nonce, o_tag, o_out_valid, o_out_nonce); end
    tests++; if (o_res_ready !== 1'b1) begin fails++; $display("FAIL async_rst_res_ready: got %b want 1", o_res_ready); end
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    repeat (4) @(negedge clk);
    tests++; if (o_valid !== 1'b0 || o_busy !== 1'b0) begin fails++; $display("FAIL post_rst_idle: got valid=%b busy=%b want 0/0", o_valid, o_busy); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_zero_count();
    test_abort_stall();
    test_out_of_order();
    test_err_and_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion want finish");
    $fatal(1, "watchdog");
  end

endmodule
